// File: rtl/seg_pkg.sv
// Shared types and constants for the four-digit seven-segment display controller.
// Segment patterns are active-low, bit 6 = segment a through bit 0 = segment g.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam logic [6:0]  SEG_BLANK   = 7'b1111111;
    localparam logic [6:0]  SEG_DASH    = 7'b1111110;
    localparam logic [3:0]  ANODE_OFF   = 4'b1111;
    localparam logic [15:0] MAX_DISPLAY = 16'd9999;

    // Index 0 is the leftmost entry's counterpart: digit 0 sits in the lowest slot.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    localparam logic [NUM_DIGITS-1:0][3:0] ANODE_PAT = {
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] r;
        r = SEG_BLANK;
        if (nib <= 4'd9) r = SEG_TABLE[nib];
        return r;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Two-source update bus for the display controller: each source offers a 16-bit
// binary value with valid, and the controller answers with a one-cycle ready.
interface seg_display_ctrl_if;
    logic        a_valid;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [15:0] b_data;
    logic        b_ready;

    modport master (output a_valid, a_data, b_valid, b_data, input a_ready, b_ready);
    modport slave  (input a_valid, a_data, b_valid, b_data, output a_ready, b_ready);
endinterface

// File: rtl/seg_display_ctrl_bin2bcd.sv
// Sequential double-dabble converter: start captures bin, then one shift per cycle;
// done is high during the 16th step so bcd is final on the following cycle.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    logic [31:0] r_shift;
    logic [3:0]  r_cnt;
    logic        r_run;
    logic        r_ovf;
    logic [31:0] w_adj;

    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_shift[16 + 4*i +: 4] >= 4'd5)
                w_adj[16 + 4*i +: 4] = r_shift[16 + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (start) begin
            r_shift <= {16'd0, bin};
            r_cnt   <= '0;
            r_run   <= 1'b1;
            r_ovf   <= (bin > MAX_DISPLAY);
        end else if (r_run) begin
            r_shift <= w_adj << 1;
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) r_run <= 1'b0;
        end
    end

    assign done = r_run && (r_cnt == 4'd15);
    assign bcd  = r_shift[31:16];
    assign ovf  = r_ovf;

endmodule

// File: rtl/seg_display_ctrl.sv
// Round-robin two-source display controller: converts the accepted value to BCD,
// swaps all digits in at once, and multiplexes four active-low digits.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter bit BLANK_LZ     = 1'b0
) (
    input  logic                     clk_100mhz,
    input  logic                     reset,
    seg_display_ctrl_if.slave        src,
    output logic [3:0]               Anode_Activate,
    output logic [6:0]               LED_out,
    output logic                     busy,
    output logic                     src_sel
);

    state_t                       r_state;
    logic                         r_last_b;
    logic                         r_src_pending;
    logic                         r_ovf;
    logic                         r_src_sel;
    logic [NUM_DIGITS-1:0][3:0]   r_digit;
    logic [REFRESH_BITS+1:0]      r_scan;

    logic        w_idle;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_start;
    logic        w_conv_done;
    logic        w_conv_ovf;
    logic [15:0] w_bcd;
    logic [1:0]  w_idx;
    logic [1:0]  w_pos;
    logic [3:0]  w_lz;
    logic [6:0]  w_seg;

    // Reset gates ready directly since the state register only clears at the edge.
    assign w_idle      = (r_state == ST_IDLE) && !reset;
    assign w_grant_a   = src.a_valid && (!src.b_valid || r_last_b);
    assign w_grant_b   = src.b_valid && (!src.a_valid || !r_last_b);
    assign src.a_ready = w_idle && w_grant_a;
    assign src.b_ready = w_idle && w_grant_b;
    assign w_start     = src.a_ready || src.b_ready;
    assign busy        = (r_state != ST_IDLE);
    assign src_sel     = r_src_sel;

    bin2bcd_seq u_conv (
        .clk   (clk_100mhz),
        .rst   (reset),
        .start (w_start),
        .bin   (src.b_ready ? src.b_data : src.a_data),
        .done  (w_conv_done),
        .bcd   (w_bcd),
        .ovf   (w_conv_ovf)
    );

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_last_b      <= 1'b1;
            r_src_pending <= 1'b0;
            r_digit       <= '0;
            r_ovf         <= 1'b0;
            r_src_sel     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state       <= ST_CONV;
                        r_src_pending <= src.b_ready;
                        r_last_b      <= src.b_ready;
                    end
                end
                ST_CONV: begin
                    if (w_conv_done) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_digit   <= w_bcd;
                    r_ovf     <= w_conv_ovf;
                    r_src_sel <= r_src_pending;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Scan index 0 drives the thousands digit, which lives in r_digit[3].
    assign w_idx = r_scan[REFRESH_BITS+1 -: 2];
    assign w_pos = 2'd3 - w_idx;
    assign w_lz  = {(r_digit[3] == 4'd0), (r_digit[3:2] == 8'd0),
                    (r_digit[3:1] == 12'd0), 1'b0};

    always_comb begin
        w_seg = seg_decode(r_digit[w_pos]);
        if (BLANK_LZ && w_lz[w_pos]) w_seg = SEG_BLANK;
        if (r_ovf) w_seg = SEG_DASH;
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_scan         <= '0;
            Anode_Activate <= ANODE_OFF;
            LED_out        <= SEG_BLANK;
        end else begin
            r_scan         <= r_scan + 1'b1;
            Anode_Activate <= ANODE_PAT[w_idx];
            LED_out        <= w_seg;
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: two instances (plain and leading-zero blanking) share stimulus.
module tb_seg_display_ctrl;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111, S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111, SD = 7'b1111110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seg_display_ctrl_if if0();
    seg_display_ctrl_if if1();
    assign if1.a_valid = if0.a_valid;
    assign if1.a_data  = if0.a_data;
    assign if1.b_valid = if0.b_valid;
    assign if1.b_data  = if0.b_data;

    logic [3:0] an0, an1;
    logic [6:0] led0, led1;
    logic       busy0, busy1, sel0, sel1;

    seg_display_ctrl #(.REFRESH_BITS(2), .BLANK_LZ(1'b0)) dut0 (
        .clk_100mhz(clk), .reset(reset), .src(if0.slave),
        .Anode_Activate(an0), .LED_out(led0), .busy(busy0), .src_sel(sel0));
    seg_display_ctrl #(.REFRESH_BITS(2), .BLANK_LZ(1'b1)) dut1 (
        .clk_100mhz(clk), .reset(reset), .src(if1.slave),
        .Anode_Activate(an1), .LED_out(led1), .busy(busy1), .src_sel(sel1));

    int checks = 0;
    int errors = 0;
    logic [27:0] cur0, cur1;
    bit last_b = 1'b1;

    typedef struct {
        bit av, bv;
        logic [15:0] ad, bd;
        bit ra, rb;
        logic [27:0] seg0, seg1;
        bit src;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dig_seg(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
            3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // pos 0 = thousands ... pos 3 = units
    function automatic logic [6:0] exp_seg(input int v, input int pos, input bit blank);
        int w = 1;
        for (int i = pos; i < 3; i++) w = w * 10;
        if (v > 9999) return 7'b1111110;
        if (blank && pos < 3 && v < w) return 7'b1111111;
        return dig_seg((v / w) % 10);
    endfunction

    function automatic logic [27:0] pack_exp(input int v, input bit blank);
        logic [27:0] r;
        r = '0;
        for (int p = 0; p < 4; p++) r[27-7*p -: 7] = exp_seg(v, p, blank);
        return r;
    endfunction

    function automatic int pos_of(input logic [3:0] an);
        case (an)
            4'b0111: return 0;
            4'b1011: return 1;
            4'b1101: return 2;
            4'b1110: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic read_display(output logic [27:0] d0, output logic [27:0] d1);
        int p;
        d0 = 'x;
        d1 = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            p = pos_of(an0);
            if (p >= 0) d0[27-7*p -: 7] = led0;
            p = pos_of(an1);
            if (p >= 0) d1[27-7*p -: 7] = led1;
        end
    endtask

    task automatic xfer(input bit av, input bit bv, input logic [15:0] ad, input logic [15:0] bd,
                        output bit ra, output bit rb, output int busy_n);
        int p;
        bit bad;
        bad = 1'b0;
        @(negedge clk);
        if0.a_valid = av; if0.b_valid = bv; if0.a_data = ad; if0.b_data = bd;
        #1;
        ra = if0.a_ready;
        rb = if0.b_ready;
        @(negedge clk);
        if0.a_valid = 1'b0; if0.b_valid = 1'b0;
        busy_n = 0;
        while (busy0 && busy_n < 40) begin
            p = pos_of(an0);
            if (p >= 0 && led0 !== cur0[27-7*p -: 7]) bad = 1'b1;
            busy_n++;
            @(negedge clk);
        end
        chk("hold_old_digits", 32'(bad), 32'd0);
    endtask

    task automatic run_txn(input string tag, input bit av, input bit bv,
                           input logic [15:0] ad, input logic [15:0] bd,
                           input bit era, input bit erb,
                           input logic [27:0] e0, input logic [27:0] e1, input bit esrc);
        bit ra, rb;
        int bn;
        logic [27:0] d0, d1;
        xfer(av, bv, ad, bd, ra, rb, bn);
        chk({tag, "_a_ready"}, 32'(ra), 32'(era));
        chk({tag, "_b_ready"}, 32'(rb), 32'(erb));
        chk({tag, "_busy_len"}, 32'(bn), 32'd17);
        if (era) last_b = 1'b0;
        if (erb) last_b = 1'b1;
        cur0 = e0;
        cur1 = e1;
        read_display(d0, d1);
        chk({tag, "_digits"}, 32'(d0), 32'(e0));
        chk({tag, "_digits_blank_lz"}, 32'(d1), 32'(e1));
        chk({tag, "_src_sel"}, 32'(sel0), 32'(esrc));
        chk({tag, "_src_sel_blank_lz"}, 32'(sel1), 32'(esrc));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] an_seq [4];
        logic [27:0] d0, d1;
        int k;
        bit wb;
        int v;
        bit av, bv;
        logic [15:0] ad, bd;

        an_seq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vecs[0] = '{1'b1, 1'b0, 16'd1234, 16'd0, 1'b1, 1'b0, {S1,S2,S3,S4}, {S1,S2,S3,S4}, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'd0, 16'd10000, 1'b0, 1'b1, {SD,SD,SD,SD}, {SD,SD,SD,SD}, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'd7, 16'd0, 1'b1, 1'b0, {S0,S0,S0,S7}, {SB,SB,SB,S7}, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, {S0,S0,S0,S0}, {SB,SB,SB,S0}, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'd11, 16'd22, 1'b0, 1'b1, {S0,S0,S2,S2}, {SB,SB,S2,S2}, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'd9999, 16'd5, 1'b1, 1'b0, {S9,S9,S9,S9}, {S9,S9,S9,S9}, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'd0, 16'd1050, 1'b0, 1'b1, {S1,S0,S5,S0}, {S1,S0,S5,S0}, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'd305, 16'd0, 1'b1, 1'b0, {S0,S3,S0,S5}, {SB,S3,S0,S5}, 1'b0};

        // Reset state, with both sources requesting
        if0.a_valid = 1'b1; if0.b_valid = 1'b1; if0.a_data = 16'd1; if0.b_data = 16'd2;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_anode", 32'(an0), 32'(4'b1111));
        chk("rst_led", 32'(led0), 32'(SB));
        chk("rst_led_blank_lz", 32'(led1), 32'(SB));
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_src_sel", 32'(sel0), 32'd0);
        chk("rst_a_ready", 32'(if0.a_ready), 32'd0);
        chk("rst_b_ready", 32'(if0.b_ready), 32'd0);
        @(negedge clk);
        if0.a_valid = 1'b0; if0.b_valid = 1'b0;
        reset = 1'b0;
        cur0 = pack_exp(0, 1'b0);
        cur1 = pack_exp(0, 1'b1);
        last_b = 1'b1;

        // Scan sequence after reset release: each anode for 4 cycles, all digits zero
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            chk("scan_anode", 32'(an0), 32'(an_seq[((n - 1) / 4) % 4]));
            chk("scan_led_zero", 32'(led0), 32'(S0));
        end

        // Contention: A wins first, B is accepted 18 edges later while A keeps requesting
        @(negedge clk);
        if0.a_valid = 1'b1; if0.a_data = 16'd11; if0.b_valid = 1'b1; if0.b_data = 16'd22;
        #1;
        chk("cont1_a_ready", 32'(if0.a_ready), 32'd1);
        chk("cont1_b_ready", 32'(if0.b_ready), 32'd0);
        @(negedge clk);
        if0.a_data = 16'd33;
        #1;
        k = 0;
        while (!(if0.a_ready || if0.b_ready) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("cont2_wait", 32'(k), 32'd17);
        chk("cont2_b_ready", 32'(if0.b_ready), 32'd1);
        chk("cont2_a_ready", 32'(if0.a_ready), 32'd0);
        @(negedge clk);
        if0.b_valid = 1'b0;
        #1;
        k = 0;
        while (!if0.a_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("cont3_wait", 32'(k), 32'd17);
        chk("cont3_src_sel_b", 32'(sel0), 32'd1);
        @(negedge clk);
        if0.a_valid = 1'b0;
        k = 0;
        while (busy0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("cont3_busy_len", 32'(k), 32'd17);
        last_b = 1'b0;
        cur0 = pack_exp(33, 1'b0);
        cur1 = pack_exp(33, 1'b1);
        read_display(d0, d1);
        chk("cont3_digits", 32'(d0), 32'(cur0));
        chk("cont3_src_sel", 32'(sel0), 32'd0);

        // Directed vectors
        for (int i = 0; i < 8; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].av, vecs[i].bv, vecs[i].ad, vecs[i].bd,
                    vecs[i].ra, vecs[i].rb, vecs[i].seg0, vecs[i].seg1, vecs[i].src);

        // Random traffic against the value-level model
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 2))
                0: begin av = 1'b1; bv = 1'b0; end
                1: begin av = 1'b0; bv = 1'b1; end
                default: begin av = 1'b1; bv = 1'b1; end
            endcase
            ad = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(10000, 65535))
                                             : 16'($urandom_range(0, 9999));
            bd = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 99))
                                             : 16'($urandom_range(0, 65535));
            wb = (av && bv) ? !last_b : bv;
            v  = wb ? int'(bd) : int'(ad);
            run_txn("rnd", av, bv, ad, bd, !wb, wb, pack_exp(v, 1'b0), pack_exp(v, 1'b1), wb);
        end

        // Reset in the middle of a conversion discards it
        run_txn("load42", 1'b1, 1'b0, 16'd42, 16'd0, 1'b1, 1'b0,
                pack_exp(42, 1'b0), pack_exp(42, 1'b1), 1'b0);
        @(negedge clk);
        if0.a_valid = 1'b1; if0.a_data = 16'd9999;
        #1;
        chk("abort_accept", 32'(if0.a_ready), 32'd1);
        @(negedge clk);
        if0.a_valid = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        if0.a_valid = 1'b1;
        #1;
        chk("abort_anode", 32'(an0), 32'(4'b1111));
        chk("abort_led", 32'(led0), 32'(SB));
        chk("abort_busy", 32'(busy0 | busy1), 32'd0);
        chk("abort_a_ready", 32'(if0.a_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        if0.a_valid = 1'b0;
        last_b = 1'b1;
        k = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy0) k++;
        end
        chk("abort_busy_after", 32'(k), 32'd0);
        read_display(d0, d1);
        chk("abort_digits", 32'(d0), 32'(pack_exp(0, 1'b0)));
        chk("abort_digits_blank_lz", 32'(d1), 32'(pack_exp(0, 1'b1)));
        chk("abort_src_sel", 32'(sel0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter REFRESH_BITS, default 18, meaning clock cycles per digit = 2^REFRESH_BITS.
REQ-002 Parameter BLANK_LZ, default 0, meaning 1 = blank leading zero digits.
REQ-003 clk_100mhz  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_valid  input  1  source A (processor result) requests a display update.
REQ-006 a_data  input  16  source A unsigned binary value.
REQ-007 a_ready  output  1  source A value accepted this cycle.
REQ-008 b_valid / b_data / b_ready  in/in/out  1/16/1  source B (debug), same semantics as A.
REQ-009 Anode_Activate  output  4  active-low digit enables; bit 3 = thousands digit.
REQ-010 LED_out  output  7  active-low segments, bit 6 = a through bit 0 = g.
REQ-011 busy  output  1  high while a value is being converted or loaded.
REQ-012 src_sel  output  1  source of the value currently displayed, 0 = A, 1 = B.

Function
REQ-013 FSM states: IDLE, CONV, LOAD; no other states are reachable.
REQ-014 In IDLE, a_ready/b_ready are combinational and go high only for the granted valid source; at most one ready is high per cycle.
REQ-015 Arbitration: round-robin; when both are valid, the source not granted last wins; a lone valid is granted immediately.
REQ-016 Handshake at edge T (valid & ready) captures data into the converter, sets src_pending, and moves to CONV with iteration count 0.
REQ-017 CONV performs one double-dabble step per cycle (add 3 to any BCD nibble >= 5, then shift left 1); after the 16th step (edge T+16), move to LOAD.
REQ-018 At edge T+17, LOAD writes all four digit registers and src_sel atomically, then returns to IDLE; ready stays low outside IDLE, so the next acceptance is no earlier than edge T+18.
REQ-019 busy = (state != IDLE).
REQ-020 A captured value > 9999 sets overflow, and every digit then displays dash 7'b1111110.
REQ-021 Scan: free-running counter of REFRESH_BITS+2 bits; its top 2 bits select the digit: 00 -> 4'b0111 thousands, 01 -> 4'b1011, 10 -> 4'b1101, 11 -> 4'b1110 units; the counter wraps silently.
REQ-022 Anode_Activate and LED_out are registered, one cycle after the scan index.
REQ-023 Digit decode: 0-9 use the standard active-low patterns (0 = 7'b0000001, 1 = 7'b1001111, 7 = 7'b0001111, 8 = 7'b0000000); an invalid nibble displays 7'b1111111.
REQ-024 When BLANK_LZ = 1, zero digits left of the first nonzero digit drive 7'b1111111; the units digit is never blanked, so value 0 shows "0".
REQ-025 The display keeps the old digits throughout CONV; no partial value is ever visible.

Reset
REQ-026 Reset forces state IDLE, digits 0, overflow 0, src_sel 0, busy 0, the scan counter 0, Anode_Activate 4'b1111 and LED_out 7'b1111111.
REQ-027 Reset sets last-grant to B, so A wins the first contention.
REQ-028 Reset asserted mid-CONV aborts the conversion, discards the captured value and loads no digits.
REQ-029 a_ready and b_ready are 0 while reset is high.

Structure
REQ-030 Shared package seg_pkg holds the FSM state enum, the digit-to-segment table, SEG_BLANK, SEG_DASH, the anode patterns and NUM_DIGITS = 4.
REQ-031 The iterative converter is a sub-module bin2bcd_seq with ports start, bin[15:0], done, bcd[15:0] and ovf; the top module owns the arbitration and scan logic.

Verification (bench uses REFRESH_BITS = 2)
REQ-032 Reset release with no valids -> Anode_Activate cycles 0111/1011/1101/1110 every 4 cycles, and every digit shows 7'b0000001.
REQ-033 a_data = 1234 with a_valid for 1 cycle -> a_ready high for that cycle, busy high for 17 cycles, then digits show 1001111, 0010010, 0000110, 1001100 and src_sel = 0.
REQ-034 a_valid and b_valid high together (A = 11, B = 22) -> A is accepted first and B at edge T+18; in the next contention B wins over A.
REQ-035 b_data = 10000 -> all four digits show 7'b1111110 and src_sel = 1.
REQ-036 Load 42, then load 9999 with reset pulsed at CONV step 8 -> digits show 0 with blank outputs during reset, the 9999 value is never shown, and busy = 0.
REQ-037 BLANK_LZ = 1: value 7 -> three blank digits, units 7'b0001111; value 0 -> units 7'b0000001.
